// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter sharing the vga_adapter pixel-write port between two
// valid/ready pixel streams, with frame range checking and saturating counters.
module vga_plot_arbiter #(
  parameter int X_MAX   = 320,
  parameter int Y_MAX   = 240,
  parameter int COLOR_W = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [8:0]         req0_x,
  input  logic [8:0]         req1_x,
  input  logic [7:0]         req0_y,
  input  logic [7:0]         req1_y,
  input  logic [COLOR_W-1:0] req0_color,
  input  logic [COLOR_W-1:0] req1_color,
  input  logic               req0_last,
  input  logic               req1_last,
  output logic [8:0]         plot_x,
  output logic [7:0]         plot_y,
  output logic [COLOR_W-1:0] plot_color,
  output logic               plot,
  output logic               grant,
  output logic               busy,
  output logic [16:0]        pixel_count,
  output logic [15:0]        drop_count
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [9:0] XLIM = 10'(X_MAX);
  localparam logic [8:0] YLIM = 9'(Y_MAX);

  function automatic logic [16:0] sat_inc_pix(input logic [16:0] v);
    return (&v) ? v : v + 17'd1;
  endfunction

  function automatic logic [15:0] sat_inc_drop(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  state_t               state_q;
  logic                 rr_last_q;
  logic [8:0]           plot_x_q;
  logic [7:0]           plot_y_q;
  logic [COLOR_W-1:0]   plot_color_q;
  logic                 plot_q;
  logic                 grant_q;
  logic                 busy_q;
  logic [16:0]          pixel_count_q;
  logic [15:0]          drop_count_q;

  logic                 rdy0, rdy1;
  logic                 acc0, acc1, acc;
  logic [8:0]           beat_x;
  logic [7:0]           beat_y;
  logic [COLOR_W-1:0]   beat_color;
  logic                 beat_last;
  logic                 in_range;

  // In IDLE the grant goes to the only valid requester, or away from rr_last on a tie.
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            if (req0_valid && (!req1_valid || rr_last_q)) rdy0 = 1'b1;
            else if (req1_valid)                          rdy1 = 1'b1;
          end
        end
        OWN0:    rdy0 = enable;
        OWN1:    rdy1 = enable;
        default: ;
      endcase
    end
  end

  assign acc0 = rdy0 & req0_valid;
  assign acc1 = rdy1 & req1_valid;
  assign acc  = acc0 | acc1;

  assign beat_x     = acc1 ? req1_x     : req0_x;
  assign beat_y     = acc1 ? req1_y     : req0_y;
  assign beat_color = acc1 ? req1_color : req0_color;
  assign beat_last  = acc1 ? req1_last  : req0_last;
  assign in_range   = ({1'b0, beat_x} < XLIM) && ({1'b0, beat_y} < YLIM);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_last_q     <= 1'b1;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_color_q  <= '0;
      plot_q        <= 1'b0;
      grant_q       <= 1'b0;
      busy_q        <= 1'b0;
      pixel_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      plot_q <= acc && in_range;
      if (acc && in_range) begin
        plot_x_q     <= beat_x;
        plot_y_q     <= beat_y;
        plot_color_q <= beat_color;
      end
      if (acc) begin
        grant_q   <= acc1;
        rr_last_q <= acc1;
        busy_q    <= !beat_last;
        if (beat_last) state_q <= IDLE;
        else           state_q <= acc1 ? OWN1 : OWN0;
      end
      // Clear wins over a same-cycle increment.
      if (clear) begin
        pixel_count_q <= '0;
        drop_count_q  <= '0;
      end else if (acc) begin
        if (in_range) pixel_count_q <= sat_inc_pix(pixel_count_q);
        else          drop_count_q  <= sat_inc_drop(drop_count_q);
      end
    end
  end

  assign req0_ready  = rdy0;
  assign req1_ready  = rdy1;
  assign plot_x      = plot_x_q;
  assign plot_y      = plot_y_q;
  assign plot_color  = plot_color_q;
  assign plot        = plot_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign pixel_count = pixel_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: a vector table for arbitration, range
// checking, enable stall and clear, plus sequences for bursts, reset and saturation.
module tb_vga_plot_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       reset, enable, clear;
  logic       v0, v1, r0, r1, l0, l1;
  logic [8:0] x0, x1, px;
  logic [7:0] y0, y1, py;
  logic [2:0] c0, c1, pcol;
  logic       plot, grant, busy;
  logic [16:0] pcnt;
  logic [15:0] dcnt;

  int tests = 0;
  int fails = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_plot_arbiter #(.X_MAX(320), .Y_MAX(240), .COLOR_W(3)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .clear(clear),
    .req0_valid(v0), .req1_valid(v1), .req0_ready(r0), .req1_ready(r1),
    .req0_x(x0), .req1_x(x1), .req0_y(y0), .req1_y(y1),
    .req0_color(c0), .req1_color(c1), .req0_last(l0), .req1_last(l1),
    .plot_x(px), .plot_y(py), .plot_color(pcol), .plot(plot),
    .grant(grant), .busy(busy), .pixel_count(pcnt), .drop_count(dcnt)
  );

  typedef struct {
    logic en, clr, v0, l0; logic [8:0] x0; logic [7:0] y0;
    logic v1, l1; logic [8:0] x1; logic [7:0] y1;
    logic er0, er1, eplot; logic [8:0] epx; logic [7:0] epy; logic [2:0] ecol;
    logic egrant, ebusy; logic [16:0] epc; logic [15:0] edc;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(
    input logic en, input logic clr, input logic a0, input logic b0,
    input logic [8:0] ax, input logic [7:0] ay,
    input logic a1, input logic b1, input logic [8:0] bx, input logic [7:0] by,
    input logic er0, input logic er1, input logic ep, input logic [8:0] epx,
    input logic [7:0] epy, input logic [2:0] ecol, input logic eg, input logic eb,
    input logic [16:0] epc, input logic [15:0] edc);
    vec_t v;
    v.en = en; v.clr = clr; v.v0 = a0; v.l0 = b0; v.x0 = ax; v.y0 = ay;
    v.v1 = a1; v.l1 = b1; v.x1 = bx; v.y1 = by;
    v.er0 = er0; v.er1 = er1; v.eplot = ep; v.epx = epx; v.epy = epy; v.ecol = ecol;
    v.egrant = eg; v.ebusy = eb; v.epc = epc; v.edc = edc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; clear = 1'b0;
    v0 = 1'b0; l0 = 1'b0; x0 = '0; y0 = '0; c0 = 3'd5;
    v1 = 1'b0; l1 = 1'b0; x1 = '0; y1 = '0; c1 = 3'd2;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset state, with a requester already valid
    v0 = 1'b1; v1 = 1'b1;
    tick();
    tick();
    chk("rst_ready0", 32'(r0), 0);
    chk("rst_ready1", 32'(r1), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_xyc", {px, py, pcol}, 0);
    chk("rst_grant_busy", {grant, busy}, 0);
    chk("rst_pcnt", 32'(pcnt), 0);
    chk("rst_dcnt", 32'(dcnt), 0);
    idle_inputs();
    reset = 1'b0;
    tick();

    // Single 160-beat burst from req0
    for (int i = 0; i < 160; i++) begin
      v0 = 1'b1; x0 = 9'(i); y0 = 8'd40; l0 = (i == 159);
      #1;
      chk("burst_ready", {r0, r1}, 2'b10);
      tick();
      chk("burst_plot", {plot, px, py, pcol}, {1'b1, 9'(i), 8'd40, 3'd5});
    end
    v0 = 1'b0; l0 = 1'b0;
    chk("burst_pcnt", 32'(pcnt), 160);
    chk("burst_busy", 32'(busy), 0);
    tick();
    chk("burst_plot_end", 32'(plot), 0);

    // Vector table: contention, out of range, enable stall, clear
    do_reset();
    vt[0]  = mk(1,0, 1,0,10,1,   1,0,100,2,   1,0,1,10,1,5,   0,1,1,0);
    vt[1]  = mk(1,0, 1,0,11,1,   1,0,100,2,   1,0,1,11,1,5,   0,1,2,0);
    vt[2]  = mk(1,0, 1,0,12,1,   1,0,100,2,   1,0,1,12,1,5,   0,1,3,0);
    vt[3]  = mk(1,0, 1,1,13,1,   1,0,100,2,   1,0,1,13,1,5,   0,0,4,0);
    vt[4]  = mk(1,0, 1,0,50,9,   1,0,100,2,   0,1,1,100,2,2,  1,1,5,0);
    vt[5]  = mk(1,0, 1,0,50,9,   1,0,101,2,   0,1,1,101,2,2,  1,1,6,0);
    vt[6]  = mk(1,0, 1,0,50,9,   1,0,102,2,   0,1,1,102,2,2,  1,1,7,0);
    vt[7]  = mk(1,0, 1,0,50,9,   1,1,103,2,   0,1,1,103,2,2,  1,0,8,0);
    vt[8]  = mk(1,0, 0,0,0,0,    1,0,320,0,   0,1,0,103,2,2,  1,1,8,1);
    vt[9]  = mk(1,0, 0,0,0,0,    1,0,5,240,   0,1,0,103,2,2,  1,1,8,2);
    vt[10] = mk(1,0, 0,0,0,0,    1,1,319,239, 0,1,1,319,239,2,1,0,9,2);
    vt[11] = mk(1,0, 1,0,20,3,   1,1,200,4,   1,0,1,20,3,5,   0,1,10,2);
    vt[12] = mk(0,0, 1,0,21,3,   1,1,200,4,   0,0,0,20,3,5,   0,1,10,2);
    vt[13] = mk(0,0, 1,0,21,3,   1,1,200,4,   0,0,0,20,3,5,   0,1,10,2);
    vt[14] = mk(0,0, 1,0,21,3,   1,1,200,4,   0,0,0,20,3,5,   0,1,10,2);
    vt[15] = mk(1,0, 1,1,21,3,   1,1,200,4,   1,0,1,21,3,5,   0,0,11,2);
    vt[16] = mk(1,0, 0,0,0,0,    1,1,200,4,   0,1,1,200,4,2,  1,0,12,2);
    vt[17] = mk(1,1, 1,1,7,7,    0,0,0,0,     1,0,1,7,7,5,    0,0,0,0);
    vt[18] = mk(1,0, 0,0,0,0,    0,0,0,0,     0,0,0,7,7,5,    0,0,0,0);
    for (int i = 0; i < 19; i++) begin
      enable = vt[i].en; clear = vt[i].clr;
      v0 = vt[i].v0; l0 = vt[i].l0; x0 = vt[i].x0; y0 = vt[i].y0;
      v1 = vt[i].v1; l1 = vt[i].l1; x1 = vt[i].x1; y1 = vt[i].y1;
      #1;
      chk($sformatf("v%0d_ready", i), {r0, r1}, {vt[i].er0, vt[i].er1});
      tick();
      chk($sformatf("v%0d_plot", i), {plot, px, py, pcol},
          {vt[i].eplot, vt[i].epx, vt[i].epy, vt[i].ecol});
      chk($sformatf("v%0d_grant_busy", i), {grant, busy}, {vt[i].egrant, vt[i].ebusy});
      chk($sformatf("v%0d_pcnt", i), 32'(pcnt), 32'(vt[i].epc));
      chk($sformatf("v%0d_dcnt", i), 32'(dcnt), 32'(vt[i].edc));
    end

    // Reset asserted on beat 2 of a 5-beat req0 burst
    do_reset();
    for (int i = 0; i < 2; i++) begin
      v0 = 1'b1; x0 = 9'(i); y0 = 8'd5; l0 = 1'b0;
      tick();
    end
    chk("mid_pcnt_pre", 32'(pcnt), 2);
    x0 = 9'd2;
    reset = 1'b1;
    #1;
    chk("mid_ready", {r0, r1}, 2'b00);
    chk("mid_plot", 32'(plot), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_cnts", {pcnt, dcnt}, 0);
    tick();
    reset = 1'b0;
    v0 = 1'b1; x0 = 9'd0; y0 = 8'd5; l0 = 1'b0;
    v1 = 1'b1; x1 = 9'd60; y1 = 8'd6; l1 = 1'b1;
    #1;
    chk("mid_restart_ready", {r0, r1}, 2'b10);
    tick();
    chk("mid_restart_plot", {plot, grant, px}, {1'b1, 1'b0, 9'd0});

    // Drop counter saturation, then clear with a same-cycle accept
    do_reset();
    v0 = 1'b1; x0 = 9'd400; y0 = 8'd0; l0 = 1'b0;
    for (int i = 0; i < 65537; i++) @(posedge CLOCK_50);
    #1;
    chk("sat_dcnt", 32'(dcnt), 65535);
    chk("sat_pcnt", 32'(pcnt), 0);
    chk("sat_plot", 32'(plot), 0);
    x0 = 9'd1; y0 = 8'd1; l0 = 1'b1; clear = 1'b1;
    tick();
    chk("clr_plot", 32'(plot), 1);
    chk("clr_cnts", {pcnt, dcnt}, 0);
    clear = 1'b0; x0 = 9'd2;
    tick();
    chk("post_clr_pcnt", 32'(pcnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
